bcd_entry: RTL
==============

# bcd_entry

Push-button decimal entry for the board's four-digit seven-segment front end: the input-side counterpart of the binary-to-BCD display path. Three raw buttons are debounced and used to edit a four-digit BCD value, which the display path shows live. On a load press, a sequential reverse double-dabble converts the value to a 14-bit binary preset and delivers it with a one-cycle valid pulse, e.g. to preload the seconds counter.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_inc  in  1  raw, asynchronous; increments the selected digit.
- btn_next  in  1  raw, asynchronous; moves the selection to the next lower digit.
- btn_load  in  1  raw, asynchronous; starts the conversion.
- digits_bcd  out  16  entered value; [15:12] thousands … [3:0] units; feeds the display.
- sel_digit  out  2  selected digit index (3 = thousands, 0 = units).
- busy  out  1  conversion in progress.
- bin_value  out  14  converted binary; holds until the next conversion completes.
- bin_valid  out  1  one-cycle pulse when bin_value updates.

## Operation
- Each button: 2-FF synchronizer, then debounce.
  - The stable level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle clears the count.
  - A 0→1 stable transition yields one press pulse (one cycle).
- FSM states: IDLE, CONV, DONE.
- IDLE, presses handled with priority load > next > inc; only one acts per cycle, the others are dropped.
  - inc: selected digit +1; 9 wraps to 0. Other digits unchanged.
  - next: sel_digit −1; 0 wraps to 3.
  - load: 30-bit shift register ← {digits_bcd, 14'b0}, iteration counter ← 0, go to CONV.
- CONV, each cycle:
  - Shift the register right by 1.
  - Then every BCD nibble [29:26], [25:22], [21:18], [17:14] that is ≥ 8 has 3 subtracted.
  - After the 14th iteration go to DONE.
- DONE: bin_value ← shreg[13:0], bin_valid = 1, return to IDLE next cycle.
- All presses arriving while not in IDLE are discarded; digits_bcd is frozen during conversion.
- Width rule: maximum 9999 = 14'h270F fits 14 bits, so no overflow is possible.
- busy = (state != IDLE).

## Timing
- Reset values: digits_bcd=0, sel_digit=3, busy=0, bin_value=0, bin_valid=0, state IDLE, debounce stable levels 0, counters 0.
- Button latency: raw edge → press pulse = 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Edit: press pulse at cycle T → digits_bcd/sel_digit updated at T+1.
- Load: press pulse at T.
  - busy high T+1..T+15; CONV occupies T+1..T+14.
  - bin_valid and new bin_value at T+15; IDLE at T+16.
- rst mid-conversion: abort immediately, no bin_valid, all outputs to reset values.
- A press pulse coinciding with DONE is dropped.
- A button held continuously produces exactly one press.

## Structure
- Package bcd_entry_pkg: NDIG=4, BIN_W=14, SHREG_W=30, ITER=14, state enum {IDLE, CONV, DONE}.
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- Conversion datapath and FSM live in bcd_entry.

## Test plan
All scenarios with DEBOUNCE_CYCLES=4.
- Reset: after rst → digits_bcd=0x0000, sel_digit=3, busy=0, bin_valid=0, bin_value=0.
- Bounce on btn_inc:
  - 1–3-cycle glitches → no change.
  - Then held 8 cycles → digits_bcd=0x1000 exactly once; holding longer → no further increment.
- Wrap:
  - 10 inc presses → thousands digit back to 0.
  - 4 next presses → sel_digit 3→2→1→0→3.
- Conversion 0470: enter 0,4,7,0, press load → bin_valid exactly 15 cycles after load pulse, bin_value=0x1D6. Also 9999 → 0x270F, 0000 → 0x000.
- Busy lockout: inc/next/load pulses during CONV → digits_bcd, sel_digit unchanged; exactly one bin_valid.
- Reset mid-CONV at iteration 5 → no bin_valid, bin_value=0, digits_bcd=0; a fresh load afterward converts correctly.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared constants, FSM state type and the reverse double-dabble step
// used by the decimal-entry front end.
package bcd_entry_pkg;

    localparam int NDIG    = 4;                 // BCD digits on the display
    localparam int BIN_W   = 14;                // 9999 = 14'h270F fits exactly
    localparam int SHREG_W = 4 * NDIG + BIN_W;  // BCD field on top of binary field
    localparam int ITER    = 14;                // one shift per binary bit
    localparam int ITER_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // One reverse double-dabble iteration: shift right, then pull every
    // BCD nibble that reached 8 or more back down by 3.
    function automatic logic [SHREG_W-1:0] dabble_step(input logic [SHREG_W-1:0] r);
        logic [SHREG_W-1:0] s;
        s = r >> 1;
        for (int k = 0; k < NDIG; k++) begin
            if (s[BIN_W + 4*k + 3])
                s[BIN_W + 4*k +: 4] = s[BIN_W + 4*k +: 4] - 4'd3;
        end
        return s;
    endfunction

    // Increment one BCD digit, 9 wraps to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_entry_btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, stability counter and a
// single-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             rise;
    logic [CNT_W-1:0] count;

    // Synchronize, count consecutive disagreeing cycles, accept the new level
    // after DEBOUNCE_CYCLES of them; the accepted rise is registered once more.
    always_ff @(posedge clk) begin
        // NOTE: every state element here uses <= so all flops sample the
        // pre-edge values; a blocking '=' would let sync2 see this edge's sync1.
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            rise   <= 1'b0;
            press  <= 1'b0;
            count  <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            press <= rise;
            if (sync2 != stable) begin
                if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2;
                    rise   <= sync2;
                    count  <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_entry.sv
// Four-digit push-button decimal entry with sequential BCD-to-binary
// conversion of the entered value on a load press.
module bcd_entry
    import bcd_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_inc,
    input  logic               btn_next,
    input  logic               btn_load,
    output logic [4*NDIG-1:0]  digits_bcd,
    output logic [1:0]         sel_digit,
    output logic               busy,
    output logic [BIN_W-1:0]   bin_value,
    output logic               bin_valid
);

    logic inc_p;
    logic next_p;
    logic load_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .press (inc_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (next_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_load),
        .press (load_p)
    );

    state_t              state, state_next;
    logic [SHREG_W-1:0]  shreg, shreg_next;
    logic [ITER_W-1:0]   iter, iter_next;
    logic [4*NDIG-1:0]   digits_next;
    logic [1:0]          sel_next;
    logic [BIN_W-1:0]    bin_next;

    // State and datapath registers; reset returns everything to power-up values.
    always_ff @(posedge clk) begin
        // NOTE: the shift register and counter are reset too even though a
        // load overwrites them, so a mid-conversion reset leaves no stale data.
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            iter       <= '0;
            digits_bcd <= '0;
            sel_digit  <= 2'd3;
            bin_value  <= '0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            iter       <= iter_next;
            digits_bcd <= digits_next;
            sel_digit  <= sel_next;
            bin_value  <= bin_next;
        end
    end

    // Next-state and datapath updates: edits in IDLE, one dabble step per CONV cycle.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_next  = state;
        shreg_next  = shreg;
        iter_next   = iter;
        digits_next = digits_bcd;
        sel_next    = sel_digit;
        bin_next    = bin_value;

        case (state)
            IDLE: begin
                if (load_p) begin
                    shreg_next = {digits_bcd, {BIN_W{1'b0}}};
                    iter_next  = '0;
                    state_next = CONV;
                end else if (next_p) begin
                    sel_next = sel_digit - 2'd1;
                end else if (inc_p) begin
                    digits_next[{sel_digit, 2'b00} +: 4] =
                        bcd_inc(digits_bcd[{sel_digit, 2'b00} +: 4]);
                end
            end
            CONV: begin
                shreg_next = dabble_step(shreg);
                iter_next  = iter + ITER_W'(1);
                if (iter == ITER_W'(ITER - 1)) begin
                    bin_next   = shreg_next[BIN_W-1:0];
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign bin_valid = (state == DONE);

endmodule
